// File: rtl/array_read_arbiter_if.sv
// Bundle of the requester-side and array-side streams of array_read_arbiter.
// slave  : the arbiter's view (drives grants, responses and the array address).
// master : the surrounding system's view (requesters plus the array).
interface array_read_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int intN  = 8,
  parameter int addrN = 8
);
  logic [N_REQ*addrN-1:0] req_addr;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [intN-1:0]        rsp_data;
  logic [N_REQ-1:0]       rsp_valid;
  logic [N_REQ-1:0]       rsp_ready;
  logic [addrN-1:0]       arr_addr;
  logic                   arr_addr_valid;
  logic                   arr_addr_ready;
  logic [intN-1:0]        arr_data;
  logic                   arr_data_valid;
  logic                   arr_data_ready;

  modport slave (
    input  req_addr, req_valid, rsp_ready, arr_addr_ready, arr_data, arr_data_valid,
    output req_ready, rsp_data, rsp_valid, arr_addr, arr_addr_valid, arr_data_ready
  );

  modport master (
    output req_addr, req_valid, rsp_ready, arr_addr_ready, arr_data, arr_data_valid,
    input  req_ready, rsp_data, rsp_valid, arr_addr, arr_addr_valid, arr_data_ready
  );
endinterface

// File: rtl/array_read_arbiter.sv
// Shares one array read port among N_REQ requesters.
// Address side: 2-state FSM (IDLE grants, HOLD presents the address to the array).
// Data side: in-order tag FIFO routes each returned word back to its issuer.
// Optional macro ARB_FIXED_PRIO_EN: lowest-index requester always wins
// (rr_ptr held at 0); otherwise round-robin starting at rr_ptr.
module array_read_arbiter #(
  parameter int N_REQ   = 4,
  parameter int intN    = 8,
  parameter int addrN   = 8,
  parameter int MAX_OUT = 4
) (
  input logic clk,
  input logic rst,
  array_read_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state;
  logic [IW-1:0]    rr_ptr, gnt_idx, win_idx, head;
  logic [addrN-1:0] gnt_addr;
  logic             addr_valid_q;
  logic             win_found, grant, push, pop, fifo_full, fifo_empty;
  logic [IW-1:0]    tag_mem [MAX_OUT];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

  assign fifo_full  = (count == CW'(MAX_OUT));
  assign fifo_empty = (count == '0);
  assign head       = tag_mem[rd_ptr];

  // Winner pick: scan downward so the lowest-priority match is overwritten
  // by the highest-priority one (first valid at/after rr_ptr, or index 0).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = IW'(i);
      end
    end
`else
    for (int k = N_REQ-1; k >= 0; k--) begin
      if (bus.req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(rr_ptr) + k) % N_REQ);
      end
    end
`endif
  end

  // Grant only from IDLE with room for another tag; reset masks the
  // combinational ack so nothing is accepted while the system is reset.
  assign grant         = (state == IDLE) && !fifo_full && win_found && !rst;
  assign bus.req_ready = grant ? (N_REQ'(1) << win_idx) : '0;

  assign push = (state == HOLD) && bus.arr_addr_ready;
  assign pop  = bus.arr_data_valid && bus.arr_data_ready;

  assign bus.arr_addr       = gnt_addr;
  assign bus.arr_addr_valid = addr_valid_q;

  // Response routing is purely combinational; with no tag outstanding any
  // array data is left stalled rather than dropped or misdelivered.
  assign bus.rsp_data       = bus.arr_data;
  assign bus.rsp_valid      = (bus.arr_data_valid && !fifo_empty) ? (N_REQ'(1) << head) : '0;
  assign bus.arr_data_ready = !fifo_empty && bus.rsp_ready[head];

  // Address FSM: latch the winner in IDLE, hold it stable until the array takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      gnt_idx      <= '0;
      gnt_addr     <= '0;
      addr_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          gnt_idx      <= win_idx;
          gnt_addr     <= bus.req_addr[win_idx*addrN +: addrN];
          addr_valid_q <= 1'b1;
          state        <= HOLD;
        end
        HOLD: if (bus.arr_addr_ready) begin
          addr_valid_q <= 1'b0;
          state        <= IDLE;
`ifndef ARB_FIXED_PRIO_EN
          rr_ptr       <= (gnt_idx == IW'(N_REQ-1)) ? '0 : gnt_idx + IW'(1);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag FIFO pointers and occupancy; simultaneous push and pop cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Tag storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= gnt_idx;
  end
endmodule

// File: tb/tb_array_read_arbiter.sv
// Bench for array_read_arbiter: requester queues, a latency-programmable
// array model and a response scoreboard, driven one cycle at a time.
`timescale 1ns/1ps
module tb_array_read_arbiter;
  localparam int N = 4, DW = 8, AW = 8, MO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  array_read_arbiter_if #(.N_REQ(N), .intN(DW), .addrN(AW)) bus();

  array_read_arbiter #(.N_REQ(N), .intN(DW), .addrN(AW), .MAX_OUT(MO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct { int idx; logic [7:0] data; } exp_t;
  typedef struct { logic [7:0] d; int due; } pend_t;
  typedef struct { logic [15:0] cnt; logic [31:0] ord; int n; } vec_t;

  exp_t sb[$];
  pend_t pend[$];
  int grants[$];
  int gcyc[$];
  logic [7:0] rq_mem [N][8];
  int rq_hd [N];
  int rq_tl [N];
  int checks = 0, errors = 0, cyc = 0, lat = 1, first_pop = -1;
  logic addr_rdy = 1'b1;
  logic [N-1:0] rsp_rdy = '1;

  logic [N-1:0] s_rr, s_rv;
  logic [7:0]   s_rd, s_aa;
  logic         s_av, s_dr, s_dv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = (rq_hd[i] < rq_tl[i]);
      bus.req_addr[i*AW +: AW] = (rq_hd[i] < rq_tl[i]) ? rq_mem[i][rq_hd[i]] : 8'h00;
    end
    bus.rsp_ready      = rsp_rdy;
    bus.arr_addr_ready = addr_rdy;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.arr_data_valid = 1'b1;
      bus.arr_data       = pend[0].d;
    end else begin
      bus.arr_data_valid = 1'b0;
      bus.arr_data       = '0;
    end
  endtask

  // Requester i, k-th address = 0x10 + i + 0x20*k; the array returns addr+1.
  task automatic load(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      rq_mem[i][rq_tl[i]] = 8'(8'h10 + i + 32*k);
      rq_tl[i]++;
    end
  endtask

  task automatic clear();
    sb.delete(); pend.delete(); grants.delete(); gcyc.delete();
    for (int i = 0; i < N; i++) begin rq_hd[i] = 0; rq_tl[i] = 0; end
    first_pop = -1; addr_rdy = 1'b1; rsp_rdy = '1; lat = 1;
  endtask

  function automatic bit busy();
    for (int i = 0; i < N; i++) if (rq_hd[i] < rq_tl[i]) return 1'b1;
    return (sb.size() != 0) || (pend.size() != 0);
  endfunction

  // One clock: sample at negedge, score grants/responses, update models at posedge.
  task automatic cycle();
    int g;
    exp_t e;
    @(negedge clk);
    s_rr = bus.req_ready; s_rv = bus.rsp_valid; s_rd = bus.rsp_data;
    s_av = bus.arr_addr_valid; s_aa = bus.arr_addr;
    s_dr = bus.arr_data_ready; s_dv = bus.arr_data_valid;
    g = -1;
    if (s_rr != '0) begin
      chk("req_ready_onehot", 32'($onehot(s_rr)), 1);
      for (int i = N-1; i >= 0; i--) if (s_rr[i]) g = i;
      chk("grant_had_valid", 32'(rq_hd[g] < rq_tl[g]), 1);
      grants.push_back(g);
      gcyc.push_back(cyc);
      sb.push_back('{g, 8'(rq_mem[g][rq_hd[g]] + 8'h01)});
    end
    if ((s_rv & bus.rsp_ready) != '0) begin
      if (sb.size() == 0) chk("rsp_unexpected", 32'(s_rv), 0);
      else begin
        e = sb.pop_front();
        chk("rsp_route", 32'(s_rv), 32'(1) << e.idx);
        chk("rsp_data", 32'(s_rd), 32'(e.data));
      end
    end
    if (s_dv && s_dr && first_pop < 0) first_pop = cyc;
    @(posedge clk);
    if (g >= 0) rq_hd[g]++;
    if (s_av && addr_rdy) pend.push_back('{8'(s_aa + 8'h01), cyc + lat});
    if (s_dv && s_dr) void'(pend.pop_front());
    cyc++;
    #1 drive();
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (busy() && n < max) begin cycle(); n++; end
    chk("drain_done", 32'(busy()), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear();
    drive();
    #2;
    chk("reset_outs", 32'({bus.arr_addr_valid, bus.req_ready, bus.rsp_valid, bus.arr_data_ready}), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vec [4];
    int n, nb;
`ifdef ARB_FIXED_PRIO_EN
    vec[0] = '{16'h1112, 32'h00032100, 5};
    vec[1] = '{16'h0202, 32'h00002200, 4};
    vec[2] = '{16'h3000, 32'h00000333, 3};
    vec[3] = '{16'h1210, 32'h00003221, 4};
`else
    vec[0] = '{16'h1112, 32'h00003210, 5};
    vec[1] = '{16'h0202, 32'h00002020, 4};
    vec[2] = '{16'h3000, 32'h00000333, 3};
    vec[3] = '{16'h1210, 32'h00002321, 4};
`endif
    clear();
    drive();

    // Table: per-requester address counts and expected grant order.
    for (int t = 0; t < 4; t++) begin
      do_reset();
      for (int i = 0; i < N; i++) load(i, int'(vec[t].cnt[4*i +: 4]));
      drive();
      drain(200);
      chk($sformatf("vec%0d_ngrants", t), grants.size(), vec[t].n);
      for (int j = 0; j < vec[t].n && j < grants.size(); j++)
        chk($sformatf("vec%0d_grant%0d", t, j), grants[j], 32'(vec[t].ord[4*j +: 4]));
    end

    // Reset while holding an address with two tags outstanding.
    do_reset();
    lat = 40;
    load(0, 4);
    drive();
    n = 0;
    while (pend.size() < 2 && n < 50) begin cycle(); n++; end
    addr_rdy = 1'b0;
    drive();
    repeat (2) cycle();
    chk("t1_in_hold", 32'(s_av), 1);
    rst = 1'b1;
    #2;
    chk("t1_rst_av", 32'(bus.arr_addr_valid), 0);
    chk("t1_rst_rv", 32'(bus.rsp_valid), 0);
    chk("t1_rst_rr", 32'(bus.req_ready), 0);
    clear();
    pend.push_back('{8'hEE, 0});
    drive();
    #1;
    chk("t1_stray_rv", 32'(bus.rsp_valid), 0);
    chk("t1_stray_dr", 32'(bus.arr_data_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) begin
      cycle();
      chk("t1_stray_stall", 32'({s_rv, s_dr}), 0);
    end
    pend.delete();
    for (int i = 0; i < N; i++) load(i, 1);
    drive();
    drain(200);
    chk("t1_first_grant", (grants.size() > 0) ? grants[0] : -1, 0);

    // Long array latency: tag FIFO fills, grants stop until the first pop.
    do_reset();
    lat = 12;
    load(0, 6);
    drive();
    drain(300);
    nb = 0;
    foreach (gcyc[j]) if (first_pop >= 0 && gcyc[j] < first_pop) nb++;
    chk("t3_pop_seen", 32'(first_pop >= 0), 1);
    chk("t3_issued_before_pop", nb, MO);
    chk("t3_regrant_after_pop", 32'(gcyc.size() > 4 && gcyc[4] > first_pop), 1);

    // Response backpressure on the head requester.
    do_reset();
    rsp_rdy = '0;
    load(1, 1);
    drive();
    n = 0;
    cycle();
    while (!s_dv && n < 20) begin cycle(); n++; end
    chk("t4_data_arrived", 32'(s_dv), 1);
    for (int k = 0; k < 3; k++) begin
      chk("t4_dr_low", 32'(s_dr), 0);
      chk("t4_rv", 32'(s_rv), 32'h2);
      chk("t4_rd_held", 32'(s_rd), 32'h12);
      if (k < 2) cycle();
    end
    rsp_rdy = '1;
    drive();
    cycle();
    chk("t4_dr_rise", 32'(s_dr), 1);
    chk("t4_delivered", sb.size(), 0);
    drain(50);

    // Array address stall: address held stable, no further grants.
    do_reset();
    addr_rdy = 1'b0;
    load(0, 1);
    load(2, 1);
    drive();
    cycle();
    chk("t5_grant0", 32'(s_rr), 32'h1);
    repeat (4) begin
      cycle();
      chk("t5_av_held", 32'(s_av), 1);
      chk("t5_addr_held", 32'(s_aa), 32'h10);
      chk("t5_no_ready", 32'(s_rr), 0);
    end
    addr_rdy = 1'b1;
    drive();
    drain(100);
    chk("t5_ngrants", grants.size(), 2);
    chk("t5_second", (grants.size() > 1) ? grants[1] : -1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
